regacc_arb: RTL
===============

# regacc_arb

Shared register-bank access arbiter between the I2C slave datapath and the MCU firmware port. Captures the slave's single-cycle write/read strobes, shares one single-port register bank with MCU requests using round-robin arbitration, and returns read data to the slave's memory-read input. Sits between the I2C slave, the MCU bus bridge and the register bank.

## Interface
- AW, 8, register address width
- DW, 8, register data width
- WP_LO, 8'hF0, lowest write-protected offset (inclusive)
- WP_HI, 8'hFF, highest write-protected offset (inclusive)

- i_clk  in  1  single clock
- i_rstz  in  1  asynchronous active-low reset
- i_i2c_we  in  1  slave write strobe, 1-cycle pulse
- i_i2c_re  in  1  slave read strobe, 1-cycle pulse
- i_i2c_r_early  in  1  slave early-read strobe, 1-cycle pulse; treated as a read
- i_i2c_ofs  in  AW  slave offset, sampled on any strobe
- i_i2c_wdat  in  DW  slave write data, sampled on i_i2c_we
- o_rd_mem  out  1  read-data-valid pulse to slave
- o_rdat  out  DW  read data to slave, holds until next slave read
- i_mcu_req  in  1  MCU request, level, held until o_mcu_ack
- i_mcu_wr  in  1  MCU write (1) / read (0)
- i_mcu_adr  in  AW  MCU address
- i_mcu_wdat  in  DW  MCU write data
- o_mcu_ack  out  1  MCU completion pulse
- o_mcu_rdat  out  DW  MCU read data, valid with o_mcu_ack, held after
- i_wp  in  1  write-protect enable for I2C writes
- o_wp_hit  out  1  pulse: I2C write dropped by protection
- o_mem_ce  out  1  bank chip enable
- o_mem_we  out  1  bank write enable (qualified by o_mem_ce)
- o_mem_adr  out  AW  bank address
- o_mem_wdat  out  DW  bank write data
- i_mem_rdat  in  DW  bank read data, valid cycle after read ce
- o_ovf  out  1  sticky: I2C strobe dropped, slot occupied
- o_busy  out  1  state != IDLE or any request pending

## Operation
- Reset: all outputs 0, slot empty, state IDLE, last-grant = MCU (I2C wins first tie).
- I2C slot: one-deep {valid, wr, adr, wdat}. Strobe loads slot when empty or being granted same cycle. Strobe with slot occupied and not granted: dropped, o_ovf <= 1 (cleared only by reset). we and re/r_early together: write loaded, read dropped, o_ovf <= 1.
- MCU eligible when i_mcu_req=1 and no MCU access in flight/acking.
- States: IDLE, RD_I2C, RD_MCU.
- IDLE: no eligible requester -> ce=0. One eligible -> grant it. Both -> grant opposite of last-grant; update last-grant.
- Grant write: ce=1, we=1, adr/wdat from winner this cycle; stay IDLE (back-to-back writes allowed). Grant read: ce=1, we=0; go RD_I2C / RD_MCU.
- RD_x: ce=0; register i_mem_rdat into o_rdat or o_mcu_rdat at cycle end; return IDLE.
- Protected I2C write (i_wp=1, WP_LO <= adr <= WP_HI): granted normally but ce forced 0; o_wp_hit pulses next cycle. MCU writes never protected.
- Outputs o_mem_* combinational from state/slot/MCU inputs; o_mem_adr/wdat 0 when ce=0.

## Timing
- I2C read: strobe cycle t -> slot valid t+1 -> ce at t+1 if won -> data registered end t+2 -> o_rd_mem=1 in t+3. Latency 3 cycles uncontended, 5 worst case (one MCU read ahead).
- I2C write: ce in t+1 uncontended.
- MCU: req seen cycle c, ce in c if won; write ack c+1; read ack c+2 with o_mcu_rdat. MCU must drop or change req in ack cycle; ack cycle never regrants MCU.
- Slot freed the cycle its ce is issued.
- o_wp_hit, o_mcu_ack, o_rd_mem: exactly one cycle each.

## Configuration
- REGACC_ARB_WPROT_EN defined: i_wp, WP_LO/WP_HI range check and o_wp_hit active as above.
- Undefined: no protection; i_wp ignored, o_wp_hit tied 0, all I2C writes reach the bank.

## Test plan
- Reset: all outputs 0; i2c_re at ofs 8'h12, bank holds 8'hA5 -> ce/adr 8'h12 at t+1, o_rd_mem with o_rdat=8'hA5 at t+3.
- MCU write 8'h40<=8'h3C then read 8'h40 -> write ce same cycle, ack next; read ack 2 cycles later, o_mcu_rdat=8'h3C.
- Tie: i2c_we (8'h05<=8'h77) and MCU read pending same cycle after reset -> I2C granted first, MCU next cycle; second tie goes MCU first.
- Overflow: MCU read occupying bank, two i2c_re pulses in consecutive cycles -> second dropped, o_ovf=1 until reset.
- WPROT_EN, i_wp=1: i2c_we to 8'hF3 -> no ce, o_wp_hit one pulse; to 8'hEF -> written. i_wp=0: 8'hF3 written.
- i_rstz low during RD_I2C -> no o_rd_mem, slot cleared, state IDLE, o_ovf=0.

Source files
------------

// File: rtl/regacc_arb.sv
// Round-robin arbiter sharing one single-port register bank between I2C slave strobes and MCU.
// Optional I2C write protection is built when REGACC_ARB_WPROT_EN is defined.
module regacc_arb #(
    parameter int unsigned    AW    = 8,
    parameter int unsigned    DW    = 8,
    parameter logic [AW-1:0]  WP_LO = 8'hF0,
    parameter logic [AW-1:0]  WP_HI = 8'hFF
) (
    input  logic          i_clk,
    input  logic          i_rstz,
    input  logic          i_i2c_we,
    input  logic          i_i2c_re,
    input  logic          i_i2c_r_early,
    input  logic [AW-1:0] i_i2c_ofs,
    input  logic [DW-1:0] i_i2c_wdat,
    output logic          o_rd_mem,
    output logic [DW-1:0] o_rdat,
    input  logic          i_mcu_req,
    input  logic          i_mcu_wr,
    input  logic [AW-1:0] i_mcu_adr,
    input  logic [DW-1:0] i_mcu_wdat,
    output logic          o_mcu_ack,
    output logic [DW-1:0] o_mcu_rdat,
    input  logic          i_wp,
    output logic          o_wp_hit,
    output logic          o_mem_ce,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_adr,
    output logic [DW-1:0] o_mem_wdat,
    input  logic [DW-1:0] i_mem_rdat,
    output logic          o_ovf,
    output logic          o_busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRdI2c = 2'd1;
    localparam logic [1:0] StRdMcu = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          slot_vld_q, slot_vld_d;
    logic          slot_wr_q, slot_wr_d;
    logic [AW-1:0] slot_adr_q, slot_adr_d;
    logic [DW-1:0] slot_wdat_q, slot_wdat_d;
    logic          last_mcu_q, last_mcu_d;
    logic          ack_q, ack_d;
    logic          rd_mem_q, rd_mem_d;
    logic          wp_hit_q, wp_hit_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] rdat_q, mcu_rdat_q;

    logic i2c_elig, mcu_elig, tie, gnt_i2c, gnt_mcu;
    logic wp_match, wp_block;
    logic strobe_rd, strobe, slot_free;

    // The ack cycle never regrants the MCU, so a held request is not served twice.
    assign i2c_elig = (state_q == StIdle) && slot_vld_q;
    assign mcu_elig = (state_q == StIdle) && i_mcu_req && !ack_q;
    assign tie      = i2c_elig && mcu_elig;
    assign gnt_i2c  = i2c_elig && (!mcu_elig || last_mcu_q);
    assign gnt_mcu  = mcu_elig && !gnt_i2c;
    assign wp_block = gnt_i2c && slot_wr_q && wp_match;

`ifdef REGACC_ARB_WPROT_EN
    assign wp_match = i_wp && ({1'b0, slot_adr_q} >= {1'b0, WP_LO})
                           && ({1'b0, slot_adr_q} <= {1'b0, WP_HI});
    assign o_wp_hit = wp_hit_q;
`else
    logic unused_wp;
    assign wp_match  = 1'b0;
    assign o_wp_hit  = 1'b0;
    assign unused_wp = ^{i_wp, WP_LO, WP_HI, wp_hit_q};
`endif

    always_comb begin
        state_d    = state_q;
        o_mem_ce   = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_adr  = '0;
        o_mem_wdat = '0;
        case (state_q)
            StIdle: begin
                if (gnt_i2c) begin
                    if (!wp_block) begin
                        o_mem_ce   = 1'b1;
                        o_mem_we   = slot_wr_q;
                        o_mem_adr  = slot_adr_q;
                        o_mem_wdat = slot_wr_q ? slot_wdat_q : '0;
                    end
                    if (!slot_wr_q) state_d = StRdI2c;
                end else if (gnt_mcu) begin
                    o_mem_ce   = 1'b1;
                    o_mem_we   = i_mcu_wr;
                    o_mem_adr  = i_mcu_adr;
                    o_mem_wdat = i_mcu_wr ? i_mcu_wdat : '0;
                    if (!i_mcu_wr) state_d = StRdMcu;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign strobe_rd = i_i2c_re | i_i2c_r_early;
    assign strobe    = i_i2c_we | strobe_rd;
    assign slot_free = !slot_vld_q || gnt_i2c;

    always_comb begin
        slot_vld_d  = slot_vld_q && !gnt_i2c;
        slot_wr_d   = slot_wr_q;
        slot_adr_d  = slot_adr_q;
        slot_wdat_d = slot_wdat_q;
        if (strobe && slot_free) begin
            slot_vld_d = 1'b1;
            slot_wr_d  = i_i2c_we;
            slot_adr_d = i_i2c_ofs;
            if (i_i2c_we) slot_wdat_d = i_i2c_wdat;
        end
        // Write wins a simultaneous write/read strobe; the read counts as lost.
        ovf_d      = ovf_q | (strobe && !slot_free) | (i_i2c_we && strobe_rd);
        last_mcu_d = tie ? gnt_mcu : last_mcu_q;
        ack_d      = (gnt_mcu && i_mcu_wr) || (state_q == StRdMcu);
        rd_mem_d   = (state_q == StRdI2c);
        wp_hit_d   = wp_block;
    end

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            state_q     <= StIdle;
            slot_vld_q  <= 1'b0;
            slot_wr_q   <= 1'b0;
            slot_adr_q  <= '0;
            slot_wdat_q <= '0;
            last_mcu_q  <= 1'b1;
            ack_q       <= 1'b0;
            rd_mem_q    <= 1'b0;
            wp_hit_q    <= 1'b0;
            ovf_q       <= 1'b0;
            rdat_q      <= '0;
            mcu_rdat_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_vld_q  <= slot_vld_d;
            slot_wr_q   <= slot_wr_d;
            slot_adr_q  <= slot_adr_d;
            slot_wdat_q <= slot_wdat_d;
            last_mcu_q  <= last_mcu_d;
            ack_q       <= ack_d;
            rd_mem_q    <= rd_mem_d;
            wp_hit_q    <= wp_hit_d;
            ovf_q       <= ovf_d;
            if (state_q == StRdI2c) rdat_q <= i_mem_rdat;
            if (state_q == StRdMcu) mcu_rdat_q <= i_mem_rdat;
        end
    end

    assign o_rd_mem   = rd_mem_q;
    assign o_rdat     = rdat_q;
    assign o_mcu_ack  = ack_q;
    assign o_mcu_rdat = mcu_rdat_q;
    assign o_ovf      = ovf_q;
    assign o_busy     = (state_q != StIdle) || slot_vld_q || i_mcu_req;

endmodule
